// File: rtl/layer_scheduler.sv
// Sequencer that launches enabled layer engines in index order, watches their busy
// handshakes with start/run timeouts, and reports completion, faults and run length.
module layer_scheduler #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned LW         = 2,
  parameter int unsigned START_TO   = 8,
  parameter int unsigned RUN_TO     = 1048575
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layerEn,
  input  logic [NUM_LAYERS-1:0] layerBusy,
  output logic [NUM_LAYERS-1:0] layerStart,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            errCode,
  output logic [LW-1:0]         curLayer,
  output logic [23:0]           cycleCount
);

  localparam int unsigned TMax = (START_TO > RUN_TO) ? START_TO : RUN_TO;
  localparam int unsigned TW   = $clog2(TMax + 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitBusy, StWaitDone, StSelect, StDone, StError
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LAYERS-1:0]   en_q, en_d;
  logic [NUM_LAYERS-1:0]   ls_q, ls_d;
  logic [LW-1:0]           cur_q, cur_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [1:0]              code_q, code_d;
  logic [23:0]             cnt_q, cnt_d;
  logic                    start_q;
  logic                    armed_q;
  logic                    start_edge;
  logic                    first_found, next_found;
  logic [LW-1:0]           first_idx, next_idx;

  // armed stays low after reset until start has been seen low, so a level held
  // across reset release cannot masquerade as a fresh edge.
  assign start_edge = start & ~start_q & armed_q;

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerEn[i]) begin
        first_found = 1'b1;
        first_idx   = LW'(i);
      end
      if (en_q[i] && (i > int'(cur_q))) begin
        next_found = 1'b1;
        next_idx   = LW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    code_d  = code_q;
    ls_d    = '0;
    cnt_d   = cnt_q;
    if (state_q != StIdle && cnt_q != 24'hFF_FFFF) begin
      cnt_d = cnt_q + 24'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge && !abort) begin
          en_d   = layerEn;
          cnt_d  = '0;
          err_d  = 1'b0;
          code_d = 2'b00;
          if (first_found) begin
            cur_d   = first_idx;
            state_d = StLaunch;
          end else begin
            cur_d   = '0;
            state_d = StDone;
          end
        end
      end
      StLaunch: begin
        state_d = StWaitBusy;
        tmo_d   = '0;
      end
      StWaitBusy: begin
        if (layerBusy[cur_q]) begin
          state_d = StWaitDone;
          tmo_d   = '0;
        end else if (tmo_q == TW'(START_TO - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = 2'b01;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWaitDone: begin
        if (!layerBusy[cur_q]) begin
          state_d = StSelect;
        end else if (tmo_q == TW'(RUN_TO - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StSelect: begin
        if (next_found) begin
          cur_d   = next_idx;
          state_d = StLaunch;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides any completion or timeout decided above.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      cur_d   = cur_q;
      err_d   = err_q;
      code_d  = code_q;
    end

    if (state_d == StLaunch) begin
      ls_d[cur_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      en_q    <= '0;
      ls_q    <= '0;
      cur_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      cnt_q   <= '0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ls_q    <= ls_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      start_q <= start;
      armed_q <= armed_q | ~start;
    end
  end

  assign layerStart = ls_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign error      = err_q;
  assign errCode    = code_q;
  assign curLayer   = cur_q;
  assign cycleCount = cnt_q;

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sequenced layer engines (conv, pool, dense1, dense2).
REQ-002 SHALL have parameter LW, default 2, width of layer index (clog2 NUM_LAYERS).
REQ-003 SHALL have parameter START_TO, default 8, max cycles from layerStart to layerBusy rising.
REQ-004 SHALL have parameter RUN_TO, default 1048575, max cycles a layer may stay busy.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  run request, rising edge sensitive.
REQ-008 SHALL have port abort  input  1  cancel current run.
REQ-009 SHALL have port layerEn  input  NUM_LAYERS  per-layer enable mask, sampled on run start.
REQ-010 SHALL have port layerBusy  input  NUM_LAYERS  busy outputs of the layer controllers.
REQ-011 SHALL have port layerStart  output  NUM_LAYERS  one-hot start pulse to layer controllers.
REQ-012 SHALL have port busy  output  1  high while a run is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse on successful run completion.
REQ-014 SHALL have port error  output  1  sticky fault flag.
REQ-015 SHALL have port errCode  output  2  01 start timeout, 10 run timeout, 00 none.
REQ-016 SHALL have port curLayer  output  LW  index of active (or faulting) layer.
REQ-017 SHALL have port cycleCount  output  24  cycles consumed by the last/current run.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, SELECT, DONE, ERROR.
REQ-019 SHALL detect run start in IDLE as start=1 with registered previous start=0; start level held high SHALL NOT retrigger.
REQ-020 On run start SHALL latch layerEn, clear cycleCount, error, errCode; go to LAUNCH on lowest enabled index, or to DONE if mask is zero.
REQ-021 LAUNCH SHALL last exactly 1 cycle, assert layerStart[curLayer] only, then go WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL go WAIT_DONE when layerBusy[curLayer]=1; after START_TO cycles without it SHALL go ERROR with errCode=01.
REQ-023 WAIT_DONE SHALL go SELECT when layerBusy[curLayer]=0; after RUN_TO busy cycles SHALL go ERROR with errCode=10.
REQ-024 SELECT (1 cycle) SHALL pick next enabled index above curLayer -> LAUNCH, none left -> DONE.
REQ-025 DONE SHALL last 1 cycle asserting done=1, then IDLE; curLayer holds last launched index.
REQ-026 ERROR SHALL last 1 cycle setting error=1 and errCode, then IDLE; error/errCode/curLayer hold until next run start or rst.
REQ-027 busy SHALL be 1 in every state except IDLE; busy=0 in DONE/ERROR exit cycle's successor.
REQ-028 Timeout counter SHALL reset on entry to WAIT_BUSY and WAIT_DONE.
REQ-029 cycleCount SHALL increment each non-IDLE cycle, saturate at 0xFFFFFF, hold in IDLE.
REQ-030 layerBusy bits other than curLayer SHALL be ignored; start edges while busy=1 SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE next cycle: no done, no error, layerStart=0; abort wins over simultaneous timeout/completion.
REQ-032 abort in IDLE SHALL have no effect; abort and start edge together in IDLE SHALL not start a run.
REQ-033 layerStart SHALL be registered, glitch-free, never more than one bit high.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE and layerStart=0, busy=0, done=0, error=0, errCode=00, curLayer=0, cycleCount=0, start-edge register=0, from any state including mid-run.

Verification
REQ-035 layerEn=1111, each layer rises busy 2 cycles after start, stays 10 cycles -> layerStart pulses order 0,1,2,3, one done pulse, error=0.
REQ-036 layerEn=0101 -> only layerStart[0] and [2] pulse, curLayer=2 at done; layerEn=0000 -> done 2 cycles after start edge, cycleCount=1.
REQ-037 layer 1 never asserts busy -> ERROR after 8 WAIT_BUSY cycles, error=1, errCode=01, curLayer=1, no done.
REQ-038 abort during WAIT_DONE of layer 2 -> IDLE next cycle, busy=0, done=0, error=0; new start edge runs cleanly.
REQ-039 rst asserted mid-WAIT_DONE -> all outputs at reset values next cycle; start held high across rst release does not start a run until it toggles.
